// File: rtl/div_unit_pkg.sv
// Shared definitions for the RV32M divide unit: operation encodings, FSM states
// and the fixed results returned for divide-by-zero and signed overflow.
package div_unit_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } div_state_e;

  localparam logic [XLEN-1:0] DIV_ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] DIV_MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder and subtract the divisor if it fits.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic [W-1:0] quo_next
);

  // Two guard bits: the shifted remainder can reach 2^(W+1)-1, so a single
  // extra bit cannot distinguish a large positive difference from a negative one.
  logic [W+1:0] trial;
  logic         fits;

  assign trial    = {1'b0, rem, quo[W-1]} - {2'b00, divisor};
  assign fits     = ~trial[W+1];
  assign rem_next = fits ? trial[W-1:0] : {rem[W-2:0], quo[W-1]};
  assign quo_next = {quo[W-2:0], fits};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle RV32M divide/remainder unit: 32 restoring iterations plus a
// sign-correction cycle, with single-cycle handling of the RISC-V corner cases.
module div_unit #(
  parameter int XLEN = div_unit_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  import div_unit_pkg::*;

  localparam int CW = $clog2(XLEN);

  div_state_e      state_q, state_d;
  div_op_e         op_q;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q;
  logic [CW-1:0]   count_q;
  logic            quo_neg_q, rem_neg_q, special_q;
  logic            busy_q, done_q;
  logic [XLEN-1:0] result_q;

  logic            accept, signed_in, is_rem_in, div_zero, overflow, special_in;
  logic [XLEN-1:0] dvd_abs, dvs_abs, special_val;
  logic [XLEN-1:0] rem_step, quo_step;
  logic            busy_d, done_d;
  logic [XLEN-1:0] fix_val;

  assign accept    = (state_q == IDLE) && start && !flush;
  assign signed_in = ~op[0];
  assign is_rem_in = op[1];
  assign dvd_abs   = (signed_in && dividend[XLEN-1]) ? -dividend : dividend;
  assign dvs_abs   = (signed_in && divisor[XLEN-1])  ? -divisor  : divisor;
  assign div_zero  = (divisor == '0);
  assign overflow  = signed_in && (dividend == DIV_MIN_INT) && (divisor == DIV_ALL_ONES);
  assign special_in = div_zero || overflow;

  // Corner-case results are staged in quo so FIX can emit them unchanged.
  assign special_val = div_zero ? (is_rem_in ? dividend : DIV_ALL_ONES)
                                : (is_rem_in ? '0 : DIV_MIN_INT);

  div_step #(.W(XLEN)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = special_in ? FIX : CALC;
      CALC:    if (count_q == '1) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush && state_q != IDLE) state_d = IDLE;
  end

  // busy stays low for corner cases, which finish without stalling the pipeline.
  always_comb begin
    busy_d = (state_d == CALC) || (state_d == FIX && state_q == CALC);
    done_d = (state_q == FIX) && !flush;
    if (special_q)
      fix_val = quo_q;
    else if (op_q[1])
      fix_val = rem_neg_q ? -rem_q : rem_q;
    else
      fix_val = quo_neg_q ? -quo_q : quo_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= DIV_OP_DIV;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      count_q   <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      special_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      if (done_d) result_q <= fix_val;
      if (accept) begin
        op_q      <= div_op_e'(op);
        rem_q     <= '0;
        quo_q     <= special_in ? special_val : dvd_abs;
        dvs_q     <= dvs_abs;
        count_q   <= '0;
        quo_neg_q <= signed_in && (dividend[XLEN-1] ^ divisor[XLEN-1]);
        rem_neg_q <= signed_in && dividend[XLEN-1];
        special_q <= special_in;
      end else if (state_q == CALC) begin
        rem_q   <= rem_step;
        quo_q   <= quo_step;
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed RISC-V corner cases, flush/reset
// behaviour and randomized operations checked against an arithmetic model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] result;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] last_res;

  div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .dividend(dividend),
    .divisor(divisor), .flush(flush), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation did not terminate");
  end

  function automatic logic [31:0] model_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
    case (o)
      2'b00:   return sa / sb;
      2'b01:   return a / b;
      2'b10:   return sa % sb;
      default: return a % b;
    endcase
  endfunction

  function automatic bit model_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one operation and follows it to done; poke_at injects a start while busy.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                               input int poke_at, output int lat, output int busy_cnt,
                               output int overlap, output logic [31:0] res);
    lat = 0; busy_cnt = 0; overlap = 0; res = 'x;
    @(negedge clk);
    start = 1'b1; op = o; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    while (lat <= 40) begin
      if (busy) busy_cnt++;
      if (busy && done) overlap++;
      if (done) begin
        res = result;
        break;
      end
      if (lat == poke_at) begin
        @(negedge clk);
        start = 1'b1; op = ~o; dividend = $urandom; divisor = $urandom;
        @(posedge clk); #1;
        start = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
      lat++;
    end
  endtask

  task automatic check_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int poke_at);
    int lat, bc, ov;
    logic [31:0] res;
    bit sp;
    sp = model_special(o, a, b);
    applyStimulus(o, a, b, poke_at, lat, bc, ov, res);
    checkOutput({tag, ".result"}, res, model_result(o, a, b));
    checkOutput({tag, ".latency"}, lat, sp ? 32'd1 : 32'd33);
    checkOutput({tag, ".busy_cycles"}, bc, sp ? 32'd0 : 32'd33);
    checkOutput({tag, ".busy_and_done"}, ov, 32'd0);
    last_res = res;
  endtask

  initial begin
    logic [31:0] prev;
    int done_seen;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.busy", busy, 32'd0);
    checkOutput("reset.done", done, 32'd0);
    checkOutput("reset.result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    check_op("divu_100_7", 2'b01, 32'd100, 32'd7, -1);
    checkOutput("divu_100_7.const", last_res, 32'd14);
    check_op("remu_100_7", 2'b11, 32'd100, 32'd7, -1);
    checkOutput("remu_100_7.const", last_res, 32'd2);
    check_op("div_m100_7", 2'b00, -32'sd100, 32'd7, -1);
    checkOutput("div_m100_7.const", last_res, 32'hFFFF_FFF2);
    check_op("rem_m100_7", 2'b10, -32'sd100, 32'd7, -1);
    checkOutput("rem_m100_7.const", last_res, 32'hFFFF_FFFE);
    check_op("rem_100_m7", 2'b10, 32'd100, -32'sd7, -1);
    checkOutput("rem_100_m7.const", last_res, 32'd2);
    check_op("divu_by0", 2'b01, 32'h1234, 32'd0, -1);
    checkOutput("divu_by0.const", last_res, 32'hFFFF_FFFF);
    check_op("rem_by0", 2'b10, 32'h1234, 32'd0, -1);
    checkOutput("rem_by0.const", last_res, 32'h1234);
    check_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    checkOutput("div_ovf.const", last_res, 32'h8000_0000);
    check_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    checkOutput("rem_ovf.const", last_res, 32'd0);
    check_op("div_minint_3", 2'b00, 32'h8000_0000, 32'd3, -1);

    check_op("ignore_start", 2'b01, 32'd1000, 32'd3, 5);
    checkOutput("ignore_start.const", last_res, 32'd333);

    // Flush mid-CALC, then a fresh start ten cycles later.
    prev = result;
    @(negedge clk);
    start = 1'b1; op = 2'b01; dividend = 32'hDEAD_BEEF; divisor = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("flush.busy", busy, 32'd0);
    checkOutput("flush.done", done, 32'd0);
    done_seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done || busy) done_seen++;
    end
    checkOutput("flush.quiet", done_seen, 32'd0);
    checkOutput("flush.result_held", result, prev);
    check_op("after_flush", 2'b01, 32'd77777, 32'd13, -1);

    // Flush and start in the same idle cycle: the start is dropped.
    prev = result;
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'b01; dividend = 32'd50; divisor = 32'd0;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    checkOutput("flush_start.busy", busy, 32'd0);
    done_seen = 0;
    repeat (4) begin
      if (done || busy) done_seen++;
      @(posedge clk); #1;
    end
    checkOutput("flush_start.quiet", done_seen, 32'd0);
    checkOutput("flush_start.result_held", result, prev);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    start = 1'b1; op = 2'b01; dividend = 32'd123456; divisor = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst.busy", busy, 32'd0);
    checkOutput("async_rst.done", done, 32'd0);
    checkOutput("async_rst.result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check_op("after_rst", 2'b01, 32'hFFFF_FFFF, 32'd1, -1);
    checkOutput("after_rst.const", last_res, 32'hFFFF_FFFF);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      int sel;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'($urandom_range(0, 15));
        4: rb = -32'($urandom_range(1, 15));
        default: ;
      endcase
      check_op("random", ro, ra, rb, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
